// File: rtl/operand_fetch.sv
// operand_fetch: regfile read initiator with same-edge write bypass and a one-slot operand buffer to EX
module operand_fetch #(
    parameter int INFO_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_rj,
    input  logic [4:0]        id_rk,
    input  logic [INFO_W-1:0] id_info,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_we,
    input  logic [4:0]        wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_src1,
    output logic [DATA_W-1:0] ex_src2,
    output logic [INFO_W-1:0] ex_info
);
    logic [4:0]        idx1, idx2;
    logic              hit1, hit2, accept;
    logic [DATA_W-1:0] bdata;
    assign id_ready  = ~flush & (~ex_valid | ex_ready);
    assign accept    = id_valid & id_ready;
    // held indices are re-read every stall cycle so regfile writes keep flowing into the slot
    assign rf_raddr1 = ~resetn ? 5'd0 : accept ? id_rj : idx1;
    assign rf_raddr2 = ~resetn ? 5'd0 : accept ? id_rk : idx2;
    assign ex_src1   = hit1 ? bdata : rf_rdata1;
    assign ex_src2   = hit2 ? bdata : rf_rdata2;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid <= 1'b0;
            idx1     <= '0;
            idx2     <= '0;
            ex_info  <= '0;
            hit1     <= 1'b0;
            hit2     <= 1'b0;
            bdata    <= '0;
        end else begin
            hit1  <= wb_we & (wb_waddr == rf_raddr1) & (wb_waddr != 5'd0);
            hit2  <= wb_we & (wb_waddr == rf_raddr2) & (wb_waddr != 5'd0);
            bdata <= wb_wdata;
            if (accept) begin
                ex_valid <= 1'b1;
                idx1     <= id_rj;
                idx2     <= id_rk;
                ex_info  <= id_info;
            end else if (flush | ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: drives operand_fetch against a behavioural regfile and an architectural register model
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [4:0]  id_rj = '0, id_rk = '0;
    logic [31:0] id_info = '0;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_waddr = '0;
    logic [31:0] wb_wdata = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [31:0] ex_src1, ex_src2, ex_info;

    bit   [31:0] rf_regs[32];
    bit   [31:0] m_regs[32];
    bit          m_valid;
    bit   [4:0]  m_i1, m_i2;
    bit   [31:0] m_info;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    operand_fetch #(.INFO_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_rj(id_rj), .id_rk(id_rk), .id_info(id_info),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_info(ex_info)
    );

    // 2R1W regfile: sync read returns the pre-write value, r0 hardwired to zero
    always @(posedge clk) begin
        rf_rdata1 <= rf_regs[rf_raddr1];
        rf_rdata2 <= rf_regs[rf_raddr2];
        if (wb_we && wb_waddr != 5'd0) rf_regs[wb_waddr] <= wb_wdata;
    end

    // architectural view: registers after every retired write, plus the instruction held for EX
    task automatic tick();
        @(posedge clk);
        if (wb_we && wb_waddr != 5'd0) m_regs[wb_waddr] = wb_wdata;
        if (!resetn) m_valid = 1'b0;
        else if (id_valid && !flush && (!m_valid || ex_ready)) begin
            m_valid = 1'b1; m_i1 = id_rj; m_i2 = id_rk; m_info = id_info;
        end else if (flush || ex_ready) m_valid = 1'b0;
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; wb_we = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
        total++; if (rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd0) begin bad++; $display("FAIL reset_raddr got=%0d/%0d exp=0/0", rf_raddr1, rf_raddr2); end
        tick(); tick();
        resetn = 1'b1;
        #1;
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", id_ready); end
        wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h11; tick();
        wb_waddr = 5'd6; wb_wdata = 32'h22; tick();
        wb_waddr = 5'd7; wb_wdata = 32'h1234; tick();
        wb_we = 1'b0;
    endtask

    task automatic test_basic();
        id_valid = 1'b1; id_rj = 5'd5; id_rk = 5'd6; id_info = 32'hA001; ex_ready = 1'b1;
        tick();
        id_valid = 1'b0;
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", ex_valid); end
        total++; if (ex_src1 !== 32'h11) begin bad++; $display("FAIL basic_src1 got=%h exp=11", ex_src1); end
        total++; if (ex_src2 !== 32'h22) begin bad++; $display("FAIL basic_src2 got=%h exp=22", ex_src2); end
        total++; if (ex_info !== 32'hA001) begin bad++; $display("FAIL basic_info got=%h exp=a001", ex_info); end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", ex_valid); end
    endtask

    task automatic test_bypass();
        id_valid = 1'b1; id_rj = 5'd7; id_rk = 5'd7; id_info = 32'hA002;
        wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hABCD;
        tick();
        idle();
        total++; if (ex_src1 !== 32'hABCD) begin bad++; $display("FAIL bypass_src1 got=%h exp=abcd", ex_src1); end
        total++; if (ex_src2 !== 32'hABCD) begin bad++; $display("FAIL bypass_src2 got=%h exp=abcd", ex_src2); end
        tick();
    endtask

    task automatic test_stall();
        id_valid = 1'b1; id_rj = 5'd5; id_rk = 5'd6; id_info = 32'hA003; ex_ready = 1'b0;
        tick();
        total++; if (ex_src1 !== 32'h11) begin bad++; $display("FAIL stall_first got=%h exp=11", ex_src1); end
        id_rj = 5'd9; id_info = 32'hA004;
        for (int k = 0; k < 3; k++) begin
            wb_we = (k == 1); wb_waddr = 5'd5; wb_wdata = 32'h55;
            #1;
            total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0", k, id_ready); end
            tick();
            total++; if (ex_valid !== 1'b1 || ex_info !== 32'hA003) begin bad++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/a003", k, ex_valid, ex_info); end
            total++; if (ex_src1 !== (k >= 1 ? 32'h55 : 32'h11)) begin bad++; $display("FAIL stall_src1[%0d] got=%h exp=%h", k, ex_src1, (k >= 1 ? 32'h55 : 32'h11)); end
        end
        wb_we = 1'b0; ex_ready = 1'b1;
        #1;
        total++; if (ex_src1 !== 32'h55 || id_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%h/%b exp=55/1", ex_src1, id_ready); end
        tick();
        total++; if (ex_info !== 32'hA004) begin bad++; $display("FAIL stall_next got=%h exp=a004", ex_info); end
        idle(); tick();
    endtask

    task automatic test_zero();
        id_valid = 1'b1; id_rj = 5'd0; id_rk = 5'd6; id_info = 32'hA005;
        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF;
        tick();
        idle();
        total++; if (ex_src1 !== 32'h0) begin bad++; $display("FAIL zero_src1 got=%h exp=0", ex_src1); end
        total++; if (ex_src2 !== 32'h22) begin bad++; $display("FAIL zero_src2 got=%h exp=22", ex_src2); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            id_valid = 1'b1; id_rj = 5'(i + 5); id_rk = 5'd6; id_info = 32'hB0 + 32'(i);
            tick();
            total++; if (ex_valid !== 1'b1 || ex_info !== 32'hB0 + 32'(i)) begin bad++; $display("FAIL b2b[%0d] got=%b/%h exp=1/%h", i, ex_valid, ex_info, 32'hB0 + 32'(i)); end
        end
        idle(); tick();
        for (int i = 0; i < 4; i++) begin
            id_valid = 1'b1; id_rj = 5'd5; id_rk = 5'd7; id_info = 32'hC0 + 32'(i); flush = (i == 2);
            #1;
            if (i == 2) begin
                total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", id_ready); end
            end
            tick();
            total++; if (ex_valid !== (i != 2)) begin bad++; $display("FAIL flush_valid[%0d] got=%b exp=%b", i, ex_valid, i != 2); end
            if (i != 2) begin
                total++; if (ex_info !== 32'hC0 + 32'(i)) begin bad++; $display("FAIL flush_info[%0d] got=%h exp=%h", i, ex_info, 32'hC0 + 32'(i)); end
            end
        end
        idle(); tick();
    endtask

    task automatic test_async_reset();
        id_valid = 1'b1; id_rj = 5'd5; id_rk = 5'd6; id_info = 32'hD001; ex_ready = 1'b0;
        tick();
        id_valid = 1'b0;
        tick();
        #2 resetn = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", ex_valid); end
        total++; if (rf_raddr1 !== 5'd0) begin bad++; $display("FAIL areset_raddr got=%0d exp=0", rf_raddr1); end
        tick();
        resetn = 1'b1; ex_ready = 1'b1;
        #1;
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b exp=1", id_ready); end
        id_valid = 1'b1; id_rj = 5'd5; id_rk = 5'd7; id_info = 32'hD002;
        tick();
        idle();
        total++; if (ex_valid !== 1'b1 || ex_src1 !== 32'h55 || ex_src2 !== 32'hABCD) begin bad++; $display("FAIL areset_first got=%b/%h/%h exp=1/55/abcd", ex_valid, ex_src1, ex_src2); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            id_valid = ($urandom % 4) != 0; id_rj = 5'($urandom_range(0, 7)); id_rk = 5'($urandom_range(0, 7));
            id_info = $urandom; ex_ready = ($urandom % 3) != 0; flush = ($urandom % 10) == 0;
            wb_we = $urandom % 2; wb_waddr = 5'($urandom_range(0, 7)); wb_wdata = $urandom;
            #1;
            total++; if (id_ready !== (!flush && (!m_valid || ex_ready))) begin bad++; $display("FAIL rnd_ready[%0d] got=%b", n, id_ready); end
            tick();
            total++; if (ex_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, ex_valid, m_valid); end
            if (m_valid) begin
                total++; if (ex_info !== m_info) begin bad++; $display("FAIL rnd_info[%0d] got=%h exp=%h", n, ex_info, m_info); end
                total++; if (ex_src1 !== m_regs[m_i1]) begin bad++; $display("FAIL rnd_src1[%0d] r%0d got=%h exp=%h", n, m_i1, ex_src1, m_regs[m_i1]); end
                total++; if (ex_src2 !== m_regs[m_i2]) begin bad++; $display("FAIL rnd_src2[%0d] r%0d got=%h exp=%h", n, m_i2, ex_src2, m_regs[m_i2]); end
            end
        end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_stall();
        test_zero();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
